// File: rtl/sampbuffer_pkg.sv
// Shared sample-path definitions: sample word and stream count types, used by
// the sample FIFO and by the stream select / message encode stages.
package sampbuffer_pkg;

    localparam int unsigned SAMPLE_W       = 32;
    localparam int unsigned STREAM_COUNT_W = 8;
    localparam int unsigned OVF_MAX        = 255;

    typedef logic [SAMPLE_W-1:0]       sample_t;
    typedef logic [STREAM_COUNT_W-1:0] stream_count_t;

    // Burst-sized word count: min(level, limit); limit always fits the count width.
    function automatic stream_count_t sat_count(input int unsigned level,
                                                input int unsigned limit);
        return (level > limit) ? STREAM_COUNT_W'(limit) : STREAM_COUNT_W'(level);
    endfunction

endpackage

// File: rtl/sampbuffer_ram.sv
// Sample storage: simple dual-port RAM, one write port and one synchronous
// read port (1-cycle latency), contents not reset.
//   clk     : system clock
//   wr_en   : write strobe, wr_addr/wr_data written at the edge
//   rd_addr : read address, rd_data holds mem[rd_addr] after the edge
//             (old contents when the same address is written at that edge)
module sampbuffer_ram
    import sampbuffer_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sampbuffer.sv
// Sample FIFO with first-word-fall-through stream output. Capture words are
// buffered in a synchronous RAM plus a head register; the RAM read address
// is the next read pointer, so the following word is always prefetched and
// back-to-back pulls see no bubble.
//   clk, rst           : system clock, asynchronous active-high reset
//   samp_data/valid    : capture word and write strobe
//   flush              : synchronous clear of contents and overflow count
//   samp_stream_data   : head word, valid while samp_stream_avail
//   samp_stream_count  : min(fill_level, MAX_BURST)
//   samp_stream_avail  : at least one word buffered
//   samp_stream_pull   : consumer pops the head word this cycle
//   overflow_count     : saturating count of dropped writes
//   fill_level         : words buffered, head register included
module sampbuffer
    import sampbuffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  sample_t                 samp_data,
    input  logic                    samp_valid,
    input  logic                    flush,
    output sample_t                 samp_stream_data,
    output stream_count_t           samp_stream_count,
    output logic                    samp_stream_avail,
    input  logic                    samp_stream_pull,
    output logic [7:0]              overflow_count,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] fill_nxt;
    logic          fwd_valid;
    sample_t       fwd_data;
    sample_t       ram_q;
    sample_t       head_src;
    logic          pull_ok;
    logic          full;
    logic          wr_ok;
    logic          drop;
    logic          ram_empty;
    logic          need_head;
    logic          ram_rd;
    logic          ram_wr;
    logic          fwd_nxt;

    // Accept/drop decisions, head refill source and next pointers.
    always_comb begin
        pull_ok    = samp_stream_pull & samp_stream_avail;
        full       = (fill_level == PW'(DEPTH));
        wr_ok      = samp_valid & (~full | pull_ok);
        drop       = samp_valid & ~wr_ok;
        ram_empty  = (wr_ptr == rd_ptr);
        need_head  = ~samp_stream_avail | pull_ok;
        ram_rd     = need_head & ~ram_empty;
        // With the RAM empty and the head being (re)loaded, the write bypasses into the head.
        ram_wr     = wr_ok & ~(need_head & ram_empty);
        rd_ptr_nxt = rd_ptr + PW'(ram_rd);
        // Writing the address being prefetched: the RAM returns old data, so forward the word.
        fwd_nxt    = ram_wr & (wr_ptr == rd_ptr_nxt);
        head_src   = fwd_valid ? fwd_data : ram_q;
        fill_nxt   = fill_level + PW'(wr_ok) - PW'(pull_ok);
    end

    // Pointers, head register, fill/count and overflow counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fwd_valid         <= 1'b0;
            fwd_data          <= '0;
            samp_stream_data  <= '0;
            samp_stream_avail <= 1'b0;
            samp_stream_count <= '0;
            fill_level        <= '0;
            overflow_count    <= '0;
        end else if (flush) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fwd_valid         <= 1'b0;
            fwd_data          <= '0;
            samp_stream_data  <= '0;
            samp_stream_avail <= 1'b0;
            samp_stream_count <= '0;
            fill_level        <= '0;
            overflow_count    <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            fwd_valid <= fwd_nxt;
            if (fwd_nxt) begin
                fwd_data <= samp_data;
            end
            if (need_head) begin
                if (!ram_empty) begin
                    samp_stream_data  <= head_src;
                    samp_stream_avail <= 1'b1;
                end else if (wr_ok) begin
                    samp_stream_data  <= samp_data;
                    samp_stream_avail <= 1'b1;
                end else begin
                    samp_stream_avail <= 1'b0;
                end
            end
            fill_level        <= fill_nxt;
            samp_stream_count <= sat_count(32'(fill_nxt), MAX_BURST);
            if (drop && (overflow_count != 8'(OVF_MAX))) begin
                overflow_count <= overflow_count + 8'd1;
            end
        end
    end

    sampbuffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (samp_data),
        .rd_addr (rd_ptr_nxt[AW-1:0]),
        .rd_data (ram_q)
    );

endmodule

// File: doc/sampbuffer.md
# sampbuffer

Sample FIFO feeding the sample-stream input of the serial command block. It accepts one 32-bit capture word per cycle from the sampling logic, buffers it in block RAM, and presents a first-word-fall-through stream: head word, burst-sized word count, avail and pull. It counts dropped samples on overflow so the host can detect data loss.

## Interface
- DEPTH, 512: FIFO capacity in 32-bit words; power of two, 4..4096.
- MAX_BURST, 16: saturation limit of samp_stream_count; 1..255, ≤ DEPTH.
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- samp_data  in  32  capture word.
- samp_valid  in  1  write strobe; one word per asserted cycle.
- flush  in  1  synchronous clear of contents and overflow count.
- samp_stream_data  out  32  head word, valid while samp_stream_avail.
- samp_stream_count  out  8  min(words buffered, MAX_BURST).
- samp_stream_avail  out  1  at least one word buffered.
- samp_stream_pull  in  1  consumer pops head word this cycle.
- overflow_count  out  8  saturating count of dropped writes.
- fill_level  out  log2(DEPTH)+1  words buffered, including the output register.

## Operation
- Reset (async): pointers, fill, output register valid, overflow_count all 0. All outputs 0; samp_stream_data 0.
- Storage: RAM plus one output register (head). fill_level counts both. Maximum fill is DEPTH; the RAM holds DEPTH-1 words while the head is valid.
- Write accepted when fill < DEPTH, or when fill == DEPTH and a pull is accepted in the same cycle.
- Otherwise the word is dropped and overflow_count increments, saturating at 255.
- Pull accepted only when samp_stream_avail = 1. A pull while avail = 0 is ignored, with no state change.
- Head refill: after an accepted pull, or when the head is empty, the oldest RAM word loads into the head. If the RAM is empty and a write occurs, the write data goes directly to the head (bypass).
- samp_stream_count: min(fill_level, MAX_BURST), registered. It must never exceed fill_level.
- Pointers: log2(DEPTH)+1 bits; wrap modulo 2·DEPTH. Full/empty is decided by comparing the MSBs and the remaining bits.
- Flush: the next cycle behaves as reset. A write coincident with flush is discarded and not counted as overflow. A pull coincident with flush is ignored.
- Consumer contract: stream framing may pull at most samp_stream_count words per message. The block imposes no framing of its own.

## Timing
- Write-to-avail latency: a word written at edge N into an empty FIFO appears at samp_stream_data/avail after edge N+1.
- Back-to-back pull: with pull at edge N and further words buffered, the next word is on samp_stream_data after edge N+1. Sustained throughput is 1 word/cycle with no bubble.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- fill_level and samp_stream_count update one cycle after the write/pull edge.
- Simultaneous write and pull change fill by net 0.
- RAM read is synchronous, 1 cycle. Prefetch is required to meet the no-bubble rule.

## Structure
- Sub-module sampbuffer_ram: simple dual-port, one write port and one synchronous read port, 32×DEPTH, no reset on contents.
- Shared package/header holds the sample word width (32) and the stream count width (8). These are also used by the stream select and message encode stages.
- The head register, pointer logic, count saturation and overflow counter stay in sampbuffer.

## Test plan
- Reset mid-stream: fill with 5 words, assert rst asynchronously. Required: avail = 0, count = 0, fill_level = 0 and overflow_count = 0 immediately; the first write after release appears after one cycle.
- Ordering/latency: write 0x00000001..0x00000014 back-to-back, then pull continuously. Required:
  - avail rises one cycle after the first write;
  - count saturates at 16;
  - the data sequence is exact with no bubble;
  - avail falls after the 20th pull.
- Wrap-around: 3·DEPTH words streamed with concurrent write and pull at 1/cycle. Required: no loss, overflow_count = 0, fill_level constant.
- Full boundary: fill to 512, then write 0xDEADBEEF with no pull. Required: word dropped, overflow_count = 1. Then write 0xCAFEF00D together with a pull. Required: accepted, fill stays 512, 0xCAFEF00D is the last word read.
- Overflow saturation: 300 writes while full. Required: overflow_count = 255.
- Flush and idle pull: flush with 10 words buffered and a coincident write. Required: fill 0, overflow_count 0. Then pull while empty. Required: no state change.
